// File: rtl/seg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_ctrl_pkg
// Description : Shared command codes, FSM encoding, button indices and
//               default timing for the button command scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_ctrl_pkg;

    localparam logic [1:0] OP_INC   = 2'd0;
    localparam logic [1:0] OP_DEC   = 2'd1;
    localparam logic [1:0] OP_LOAD  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_HOLD     = 2'd1;
    localparam logic [1:0] ST_REPEAT   = 2'd2;
    localparam logic [1:0] ST_WAIT_REL = 2'd3;

    // Lower index wins arbitration.
    localparam logic [1:0] BTN_R = 2'd0;
    localparam logic [1:0] BTN_L = 2'd1;
    localparam logic [1:0] BTN_U = 2'd2;
    localparam logic [1:0] BTN_D = 2'd3;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
    localparam int unsigned DEF_REPEAT_RATE     = 10_000_000;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] data;
    } cmd_t;

    function automatic logic [1:0] btn_to_op(input logic [1:0] idx);
        case (idx)
            BTN_R:   btn_to_op = OP_CLEAR;
            BTN_L:   btn_to_op = OP_LOAD;
            BTN_U:   btn_to_op = OP_INC;
            default: btn_to_op = OP_DEC;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Two-flop synchroniser, debounce counter and press pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_stable,
    output logic o_press
);

    localparam int unsigned c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic               r_stable;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= 2'b00;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_press <= 1'b0;
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_stable <= ~r_stable;
                r_press  <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_press  = r_press;

endmodule
`default_nettype wire

// File: rtl/button_command_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : button_command_scheduler
// Description : Debounces four buttons, arbitrates, auto-repeats INC/DEC and
//               presents one command at a time over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module button_command_scheduler
    import seg_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        BTNU,
    input  logic        BTND,
    input  logic        BTNR,
    input  logic        BTNL,
    input  logic [15:0] SW,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [1:0]  cmd_op,
    output logic [15:0] cmd_data,
    output logic        cmd_dropped
);

    localparam logic [31:0] c_DELAY_LAST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] c_RATE_LAST  = 32'(REPEAT_RATE - 1);

    logic [3:0]  w_raw;
    logic [3:0]  w_stable;
    logic [3:0]  w_press;
    logic        w_ev_valid;
    logic [1:0]  w_ev_idx;
    logic        w_preempt;
    logic        w_issue;
    logic [1:0]  w_issue_idx;
    logic [1:0]  w_issue_op;
    logic        w_accept;
    logic [1:0]  w_state_nxt;
    logic [1:0]  w_owner_nxt;
    logic [31:0] w_timer_nxt;

    logic [1:0]  r_state;
    logic [1:0]  r_owner;
    logic [31:0] r_timer;
    logic        r_valid;
    logic        r_dropped;
    cmd_t        r_cmd;

    assign w_raw[BTN_R] = BTNR;
    assign w_raw[BTN_L] = BTNL;
    assign w_raw[BTN_U] = BTNU;
    assign w_raw[BTN_D] = BTND;

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk      (CLK100MHZ),
            .rst_n    (CPU_RESETN),
            .i_raw    (w_raw[gi]),
            .o_stable (w_stable[gi]),
            .o_press  (w_press[gi])
        );
    end

    always_comb begin
        w_ev_valid = |w_press;
        if (w_press[BTN_R])      w_ev_idx = BTN_R;
        else if (w_press[BTN_L]) w_ev_idx = BTN_L;
        else if (w_press[BTN_U]) w_ev_idx = BTN_U;
        else                     w_ev_idx = BTN_D;
    end

    // Only CLEAR/LOAD may steal ownership, and only from a lower-priority owner.
    assign w_preempt = w_ev_valid && (w_ev_idx == BTN_R || w_ev_idx == BTN_L)
                       && (w_ev_idx < r_owner);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_timer_nxt = r_timer;
        w_issue     = 1'b0;
        w_issue_idx = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (w_ev_valid) begin
                    w_issue     = 1'b1;
                    w_issue_idx = w_ev_idx;
                    w_owner_nxt = w_ev_idx;
                    w_timer_nxt = '0;
                    w_state_nxt = (w_ev_idx == BTN_U || w_ev_idx == BTN_D) ? ST_HOLD : ST_WAIT_REL;
                end
            end
            default: begin
                if (w_preempt) begin
                    w_issue     = 1'b1;
                    w_issue_idx = w_ev_idx;
                    w_owner_nxt = w_ev_idx;
                    w_state_nxt = ST_WAIT_REL;
                end else if (!w_stable[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_state != ST_WAIT_REL) begin
                    if (r_timer == ((r_state == ST_HOLD) ? c_DELAY_LAST : c_RATE_LAST)) begin
                        w_issue     = 1'b1;
                        w_timer_nxt = '0;
                        w_state_nxt = ST_REPEAT;
                    end else begin
                        w_timer_nxt = r_timer + 32'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state <= ST_IDLE;
            r_owner <= BTN_R;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    assign w_issue_op = btn_to_op(w_issue_idx);
    assign w_accept   = !r_valid || cmd_ready;

    // A blocked CLEAR replaces the pending entry; other blocked issues are lost.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_valid   <= 1'b0;
            r_dropped <= 1'b0;
            r_cmd     <= '0;
        end else begin
            r_dropped <= 1'b0;
            if (w_issue) begin
                if (w_accept || w_issue_op == OP_CLEAR) begin
                    r_valid    <= 1'b1;
                    r_cmd.op   <= w_issue_op;
                    r_cmd.data <= (w_issue_op == OP_LOAD) ? SW : 16'h0000;
                end else begin
                    r_dropped <= 1'b1;
                end
            end else if (r_valid && cmd_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign cmd_valid   = r_valid;
    assign cmd_op      = r_cmd.op;
    assign cmd_data    = r_cmd.data;
    assign cmd_dropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_button_command_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_command_scheduler
// Description : Self-checking bench: vector table, corner sequences and
//               randomized traffic against a window-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_command_scheduler;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;
    localparam logic [1:0] K_INC = 2'd0, K_DEC = 2'd1, K_LOAD = 2'd2, K_CLEAR = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btnu, btnd, btnr, btnl;
    logic [15:0] sw;
    logic        ready;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        cmd_dropped;

    always #5 clk = ~clk;

    button_command_scheduler #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .BTNU        (btnu),
        .BTND        (btnd),
        .BTNR        (btnr),
        .BTNL        (btnl),
        .SW          (sw),
        .cmd_ready   (ready),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cmd_dropped (cmd_dropped)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a button settles once its last DB synchronised samples
    // all disagree with the settled level; samples lag the pins by two edges.
    int          hist [4][8];
    int          m_stable [4];
    int          m_press [4];
    int          m_owner;
    int          m_elapsed;
    int          m_repeated;
    logic        e_valid, e_drop;
    logic [1:0]  e_op;
    logic [15:0] e_data;

    function automatic logic [1:0] op_of(input int b);
        case (b)
            0:       return K_CLEAR;
            1:       return K_LOAD;
            2:       return K_INC;
            default: return K_DEC;
        endcase
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) hist[b][i] = 0;
            m_stable[b] = 0;
            m_press[b]  = 0;
        end
        m_owner = -1; m_elapsed = 0; m_repeated = 0;
        e_valid = 1'b0; e_drop = 1'b0; e_op = 2'd0; e_data = 16'h0;
    endtask

    task automatic model_edge();
        int raw [4];
        int ev;
        int issue;
        bit all_diff;
        if (!rst_n) begin
            model_reset();
            return;
        end
        raw[0] = int'(btnr); raw[1] = int'(btnl); raw[2] = int'(btnu); raw[3] = int'(btnd);
        ev = -1; issue = -1;
        for (int b = 3; b >= 0; b--) if (m_press[b] != 0) ev = b;
        if (m_owner < 0) begin
            if (ev >= 0) begin
                issue = ev; m_owner = ev; m_elapsed = 0; m_repeated = 0;
            end
        end else if (ev >= 0 && ev <= 1 && ev < m_owner) begin
            issue = ev; m_owner = ev;
        end else if (m_stable[m_owner] == 0) begin
            m_owner = -1;
        end else if (m_owner >= 2) begin
            m_elapsed++;
            if (m_elapsed == ((m_repeated != 0) ? RR : RD)) begin
                issue = m_owner; m_elapsed = 0; m_repeated = 1;
            end
        end
        for (int b = 0; b < 4; b++) begin
            for (int i = 7; i > 0; i--) hist[b][i] = hist[b][i-1];
            hist[b][0] = raw[b];
            all_diff = 1'b1;
            for (int i = 2; i <= DB + 1; i++) if (hist[b][i] == m_stable[b]) all_diff = 1'b0;
            m_press[b] = 0;
            if (all_diff) begin
                m_press[b]  = (m_stable[b] == 0) ? 1 : 0;
                m_stable[b] = 1 - m_stable[b];
            end
        end
        e_drop = 1'b0;
        if (issue >= 0) begin
            if (!e_valid || ready || op_of(issue) == K_CLEAR) begin
                e_valid = 1'b1;
                e_op    = op_of(issue);
                e_data  = (op_of(issue) == K_LOAD) ? sw : 16'h0;
            end else begin
                e_drop = 1'b1;
            end
        end else if (e_valid && ready) begin
            e_valid = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [19:0] a, x;
        model_edge();
        @(posedge clk);
        #1;
        a = {cmd_valid, cmd_dropped, cmd_valid ? cmd_op : 2'd0, cmd_valid ? cmd_data : 16'h0};
        x = {e_valid, e_drop, e_valid ? e_op : 2'd0, e_valid ? e_data : 16'h0};
        check("model_cycle", 32'(a), 32'(x));
        @(negedge clk);
    endtask

    task automatic set_btns(input logic [3:0] m);
        btnr = m[0]; btnl = m[1]; btnu = m[2]; btnd = m[3];
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] swv;
        int          hold;
        int          cnt;
        logic [1:0]  op;
        logic [15:0] data;
    } vec_t;

    vec_t vecs [8];
    int   cnt, first, bad, drops, drop_at;
    int   q [$];
    int   exp_rep [6] = '{7, 27, 35, 43, 51, 59};

    initial begin
        vecs[0] = '{mask:4'b0100, swv:16'h1234, hold:10, cnt:1, op:K_INC,   data:16'h0};
        vecs[1] = '{mask:4'b1000, swv:16'h1234, hold:10, cnt:1, op:K_DEC,   data:16'h0};
        vecs[2] = '{mask:4'b0101, swv:16'h5555, hold:10, cnt:1, op:K_CLEAR, data:16'h0};
        vecs[3] = '{mask:4'b0010, swv:16'hBEEF, hold:10, cnt:1, op:K_LOAD,  data:16'hBEEF};
        vecs[4] = '{mask:4'b1010, swv:16'hA5A5, hold:10, cnt:1, op:K_LOAD,  data:16'hA5A5};
        vecs[5] = '{mask:4'b0100, swv:16'h0000, hold:25, cnt:2, op:K_INC,   data:16'h0};
        vecs[6] = '{mask:4'b1100, swv:16'h0F0F, hold:10, cnt:1, op:K_INC,   data:16'h0};
        vecs[7] = '{mask:4'b0011, swv:16'h00FF, hold:10, cnt:1, op:K_CLEAR, data:16'h0};

        rst_n = 1'b0; set_btns(4'b0000); sw = 16'h0; ready = 1'b1;
        model_reset();
        #1;
        check("reset_state", 32'({cmd_valid, cmd_dropped, cmd_op, cmd_data}), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Vector table: clean press, ready high, count transfers.
        for (int v = 0; v < 8; v++) begin
            cnt = 0; first = -1; bad = 0;
            sw = vecs[v].swv; ready = 1'b1;
            for (int t = 1; t <= vecs[v].hold + 30; t++) begin
                set_btns((t <= vecs[v].hold) ? vecs[v].mask : 4'b0000);
                tick();
                if (cmd_valid) begin
                    cnt++;
                    if (first < 0) first = t;
                    if (cmd_op !== vecs[v].op || cmd_data !== vecs[v].data) bad++;
                end
            end
            check($sformatf("vec%0d_count", v), 32'(cnt), 32'(vecs[v].cnt));
            check($sformatf("vec%0d_latency", v), 32'(first), 32'd7);
            check($sformatf("vec%0d_payload", v), 32'(bad), 32'd0);
        end

        // Bouncing DEC, then held into auto-repeat; release beats a same-cycle expiry.
        ready = 1'b1; sw = 16'h0; q.delete();
        for (int i = 0; i < 3; i++) begin
            btnd = 1'b1; tick(); tick();
            btnd = 1'b0; tick(); tick();
        end
        for (int t = 1; t <= 100; t++) begin
            btnd = (t <= 60);
            tick();
            if (cmd_valid) q.push_back(t);
        end
        check("dec_repeat_count", 32'(q.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("dec_repeat_t%0d", i), (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF, 32'(exp_rep[i]));

        // U and R together, held: one CLEAR, no repeats.
        cnt = 0; bad = 0;
        for (int t = 1; t <= 130; t++) begin
            set_btns((t <= 100) ? 4'b0101 : 4'b0000);
            tick();
            if (cmd_valid) begin cnt++; if (cmd_op !== K_CLEAR) bad++; end
        end
        check("ur_clear_count", 32'(cnt), 32'd1);
        check("ur_clear_op", 32'(bad), 32'd0);

        // LOAD held in the output register while ready is low.
        sw = 16'hBEEF; ready = 1'b0; btnl = 1'b1; first = -1;
        for (int t = 1; t <= 20 && first < 0; t++) begin
            tick();
            if (cmd_valid) first = t;
        end
        check("load_latency", 32'(first), 32'd7);
        sw = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("load_held", 32'({cmd_valid, cmd_op, cmd_data}), 32'({1'b1, K_LOAD, 16'hBEEF}));
        end
        ready = 1'b1; tick();
        check("load_drained", 32'(cmd_valid), 32'd0);
        btnl = 1'b0; cnt = 0;
        for (int t = 0; t < 20; t++) begin tick(); if (cmd_valid) cnt++; end
        check("load_single", 32'(cnt), 32'd0);

        // Blocked repeat is dropped; a later CLEAR overwrites the pending INC.
        ready = 1'b0; sw = 16'h0; btnu = 1'b1; drops = 0; drop_at = -1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (cmd_dropped) begin drops++; if (drop_at < 0) drop_at = t; end
        end
        check("drop_count", 32'(drops), 32'd1);
        check("drop_time", 32'(drop_at), 32'd27);
        check("drop_pending_inc", 32'({cmd_valid, cmd_op}), 32'({1'b1, K_INC}));
        btnr = 1'b1;
        for (int t = 31; t <= 45; t++) tick();
        check("clear_overwrite", 32'({cmd_valid, cmd_op, cmd_data}), 32'({1'b1, K_CLEAR, 16'h0}));
        set_btns(4'b0000); ready = 1'b1;
        for (int t = 0; t < 30; t++) tick();

        // Async reset while INC is pending during auto-repeat.
        ready = 1'b0; btnu = 1'b1;
        for (int t = 1; t <= 32; t++) tick();
        check("pre_reset_valid", 32'(cmd_valid), 32'd1);
        rst_n = 1'b0; model_reset();
        #1;
        check("reset_async", 32'(cmd_valid), 32'd0);
        tick(); tick(); tick();
        rst_n = 1'b1; ready = 1'b1; first = -1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (cmd_valid && first < 0) first = t;
        end
        check("post_reset_latency", 32'(first), 32'd7);
        btnu = 1'b0;
        for (int t = 0; t < 30; t++) tick();

        // Randomized traffic against the model.
        for (int s = 0; s < 80; s++) begin
            logic [3:0] m;
            int len;
            m   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 30);
            sw  = 16'($urandom);
            for (int t = 0; t < len; t++) begin
                set_btns(m);
                ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            len = $urandom_range(0, 12);
            for (int t = 0; t < len; t++) begin
                set_btns(4'b0000);
                ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
